router_fsm_n: RTL and testbench

Parametrised packet-routing controller for an N-output router. It decodes the header address and tracks which destination FIFO is selected. It sequences header, payload and parity loading and handles full/empty backpressure. New behaviour: invalid-address packet dropping, per-destination soft reset, and an optional wait-till-empty timeout.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_wait_timer.sv | 30 +++
 rtl/router_fsm_n.sv | 159 +++++++++++++++
 tb/tb_router_fsm_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and defaults for the N-output packet router FSM.
//   state_t         - 4-bit FSM state encoding
//   DEF_NUM_PORTS   - default number of destination channels
//   DEF_DATA_W      - default header/payload byte width
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDR        = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        LOAD_PARITY        = 4'd4,
        CHECK_PARITY_ERROR = 4'd5,
        FIFO_FULL_STATE    = 4'd6,
        LOAD_AFTER_FULL    = 4'd7,
        DROP_PKT           = 4'd8
    } state_t;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_DATA_W    = 8;

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer: cycle counter bounding the WAIT_TILL_EMPTY dwell time.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (held while not waiting)
//   en       : count this cycle
//   expire   : en and the counter has reached LIMIT-1
module router_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(LIMIT - 1));

    // Saturates at the limit so a held expire never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/router_fsm_n.sv
// router_fsm_n: packet-routing controller for an N-output router.
// Decodes the header address, tracks the selected destination FIFO and
// sequences header/payload/parity loading with full/empty backpressure.
// Headers addressing a non-existent port are dropped. A per-port soft
// reset aborts the packet going to that port.
// Optional feature macro: ROUTER_FSM_TIMEOUT_EN -- bounds WAIT_TILL_EMPTY
// to WAIT_LIMIT cycles, then drops the packet and pulses timeout_err.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pkt_valid, data_in          source packet valid / byte
//   parity_done, low_pkt_valid  status from the register block
//   fifo_full, fifo_empty       per-FIFO status
//   sft_rst                     per-FIFO soft reset
//   busy .. rst_int_reg         Moore state decodes
//   dest_sel                    one-hot latched destination (0 when none)
//   drop_state                  packet being discarded
//   timeout_err                 one-cycle pulse on wait timeout
module router_fsm_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_W     = $clog2(NUM_PORTS),
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] sft_rst,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 drop_state,
    output logic                 timeout_err
);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || ADDR_W > DATA_W || WAIT_LIMIT < 1) begin : g_bad_param
        $error("router_fsm_n: illegal parameter combination");
    end

    // Address-to-port decode; out-of-range addresses give all zeros, which
    // both flags invalid headers and keeps per-port selects in range.
    function automatic logic [NUM_PORTS-1:0] one_hot(input logic [ADDR_W-1:0] a);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            oh[i] = (a == ADDR_W'(i));
        return oh;
    endfunction

    state_t              state, nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [NUM_PORTS-1:0] hdr_oh, q_oh;
    logic                hdr_ok, hdr_empty, q_empty, q_full, q_sft;
    logic                wait_expire;

    assign hdr_oh    = one_hot(data_in[ADDR_W-1:0]);
    assign hdr_ok    = |hdr_oh;
    assign hdr_empty = |(hdr_oh & fifo_empty);
    assign q_oh      = one_hot(addr_q);
    assign q_empty   = |(q_oh & fifo_empty);
    assign q_full    = |(q_oh & fifo_full);
    assign q_sft     = |(q_oh & sft_rst);

`ifdef ROUTER_FSM_TIMEOUT_EN
    router_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != WAIT_TILL_EMPTY),
        .en     (state == WAIT_TILL_EMPTY),
        .expire (wait_expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            timeout_err <= 1'b0;
        else
            timeout_err <= (state == WAIT_TILL_EMPTY) && (nxt == DROP_PKT);
    end
`else
    assign wait_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DECODE_ADDR;
            addr_q <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDR && pkt_valid)
                addr_q <= data_in[ADDR_W-1:0];
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            DECODE_ADDR: begin
                if (pkt_valid) begin
                    if (!hdr_ok)        nxt = DROP_PKT;
                    else if (hdr_empty) nxt = LOAD_FIRST_DATA;
                    else                nxt = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA:    nxt = LOAD_DATA;
            // Empty wins over a same-cycle timeout.
            WAIT_TILL_EMPTY: begin
                if (q_empty)          nxt = LOAD_FIRST_DATA;
                else if (wait_expire) nxt = DROP_PKT;
            end
            LOAD_DATA: begin
                if (q_full)          nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) nxt = LOAD_PARITY;
            end
            LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: nxt = q_full ? FIFO_FULL_STATE : DECODE_ADDR;
            FIFO_FULL_STATE: begin
                if (!q_full) nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        nxt = DECODE_ADDR;
                else if (low_pkt_valid) nxt = LOAD_PARITY;
                else                    nxt = LOAD_DATA;
            end
            DROP_PKT: begin
                if (!pkt_valid) nxt = DECODE_ADDR;
            end
            default:            nxt = DECODE_ADDR;
        endcase
        // Soft reset of the active port overrides timeout and normal flow.
        if (q_sft && state != DECODE_ADDR && state != DROP_PKT)
            nxt = DECODE_ADDR;
    end

    assign detect_add    = (state == DECODE_ADDR);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign drop_state    = (state == DROP_PKT);
    assign write_enb_reg = ld_state || laf_state || (state == LOAD_PARITY);
    assign busy          = lfd_state || (state == WAIT_TILL_EMPTY) || (state == LOAD_PARITY)
                         || full_state || laf_state || rst_int_reg;
    assign dest_sel      = (detect_add || drop_state) ? '0 : q_oh;

endmodule

// File: tb/tb_router_fsm_n.sv
// tb_router_fsm_n: directed scoreboard bench for router_fsm_n (NUM_PORTS=3).
// The driver pushes the hand-derived expected state/dest/timeout for each
// cycle; a monitor pops and compares one entry per clock.
module tb_router_fsm_n;

    localparam int NP = 3;
    localparam int WL = 8;

    localparam logic [3:0] S_DEC = 4'd0, S_LFD = 4'd1, S_WAIT = 4'd2, S_LD = 4'd3,
                           S_LP = 4'd4, S_CPE = 4'd5, S_FULL = 4'd6, S_LAF = 4'd7,
                           S_DROP = 4'd8;

    typedef struct packed {
        logic [3:0]    st;
        logic [NP-1:0] dest;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pkt_valid = 1'b0;
    logic [7:0]    data_in = '0;
    logic          parity_done = 1'b0;
    logic          low_pkt_valid = 1'b0;
    logic [NP-1:0] fifo_full = '0;
    logic [NP-1:0] fifo_empty = '1;
    logic [NP-1:0] sft_rst = '0;
    logic busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic write_enb_reg, rst_int_reg, drop_state, timeout_err;
    logic [NP-1:0] dest_sel;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    router_fsm_n #(.NUM_PORTS(NP), .DATA_W(8), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .sft_rst(sft_rst),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
        .dest_sel(dest_sel), .drop_state(drop_state), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, drop}
    function automatic logic [8:0] decodes(input logic [3:0] s);
        logic [8:0] d;
        d[8] = (s == S_LFD) || (s == S_WAIT) || (s == S_LP) || (s == S_FULL)
            || (s == S_LAF) || (s == S_CPE);
        d[7] = (s == S_DEC);
        d[6] = (s == S_LFD);
        d[5] = (s == S_LD);
        d[4] = (s == S_LAF);
        d[3] = (s == S_FULL);
        d[2] = (s == S_LD) || (s == S_LP) || (s == S_LAF);
        d[1] = (s == S_CPE);
        d[0] = (s == S_DROP);
        return d;
    endfunction

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                act = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                       write_enb_reg, rst_int_reg, drop_state};
                checks++;
                if (act !== decodes(e.st)) begin
                    errors++;
                    $display("FAIL decodes: got %b want %b (state %0d) t=%0t", act, decodes(e.st), e.st, $time);
                end
                checks++;
                if (dest_sel !== e.dest) begin
                    errors++;
                    $display("FAIL dest_sel: got %b want %b t=%0t", dest_sel, e.dest, $time);
                end
                checks++;
                if (timeout_err !== e.to) begin
                    errors++;
                    $display("FAIL timeout_err: got %b want %b t=%0t", timeout_err, e.to, $time);
                end
            end
        end
    end

    // Inputs are set by the caller at a negedge; this queues the state
    // expected after the coming rising edge, then waits for the next negedge.
    task automatic step(input logic [3:0] st, input logic [NP-1:0] ds, input logic to = 1'b0);
        exp_t e;
        e.st = st; e.dest = ds; e.to = to;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic hdr(input logic [7:0] h);
        pkt_valid = 1'b1;
        data_in   = h;
    endtask

    initial begin
        @(negedge clk);
        // Reset state
        rst = 1'b1; step(S_DEC, 3'b000);
        rst = 1'b0;

        // Port 1, three payload bytes, no backpressure
        hdr(8'h01);                       step(S_LFD, 3'b010);
        data_in = 8'hA1;                  step(S_LD,  3'b010);
        data_in = 8'hA2;                  step(S_LD,  3'b010);
        data_in = 8'hA3;                  step(S_LD,  3'b010);
        pkt_valid = 1'b0; data_in = 8'h5C; step(S_LP,  3'b010);
        step(S_CPE, 3'b010);
        step(S_DEC, 3'b000);

        // Port 2 busy for 5 cycles; live data_in points at an empty port 0
        fifo_empty = 3'b011; hdr(8'h02);  step(S_WAIT, 3'b100);
        data_in = 8'h00;
        for (int i = 0; i < 4; i++)       step(S_WAIT, 3'b100);
        fifo_empty = 3'b111;              step(S_LFD,  3'b100);
        data_in = 8'h11;                  step(S_LD,   3'b100);
        pkt_valid = 1'b0;                 step(S_LP,   3'b100);
        step(S_CPE, 3'b100);
        step(S_DEC, 3'b000);

        // Invalid address 3 is dropped
        hdr(8'h03);                       step(S_DROP, 3'b000);
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'h20 + i);      step(S_DROP, 3'b000);
        end
        pkt_valid = 1'b0;                 step(S_DEC,  3'b000);

        // Port 0 full for 3 cycles, then parity_done in LAF
        hdr(8'h00);                       step(S_LFD,  3'b001);
        data_in = 8'h31;                  step(S_LD,   3'b001);
        fifo_full = 3'b001;               step(S_FULL, 3'b001);
        step(S_FULL, 3'b001);
        step(S_FULL, 3'b001);
        fifo_full = 3'b000;               step(S_LAF,  3'b001);
        parity_done = 1'b1;               step(S_DEC,  3'b000);
        parity_done = 1'b0; pkt_valid = 1'b0;

        // LAF via low_pkt_valid, CPE into FULL, LAF back to LD
        hdr(8'h00);                       step(S_LFD,  3'b001);
        step(S_LD, 3'b001);
        fifo_full = 3'b001;               step(S_FULL, 3'b001);
        fifo_full = 3'b000;               step(S_LAF,  3'b001);
        low_pkt_valid = 1'b1;             step(S_LP,   3'b001);
        low_pkt_valid = 1'b0; fifo_full = 3'b001; step(S_CPE, 3'b001);
        step(S_FULL, 3'b001);
        fifo_full = 3'b000;               step(S_LAF,  3'b001);
        step(S_LD, 3'b001);
        pkt_valid = 1'b0;                 step(S_LP,   3'b001);
        step(S_CPE, 3'b001);
        step(S_DEC, 3'b000);

        // Soft reset: other port ignored, own port aborts
        hdr(8'h01);                       step(S_LFD,  3'b010);
        step(S_LD, 3'b010);
        sft_rst = 3'b001;                 step(S_LD,   3'b010);
        sft_rst = 3'b010;                 step(S_DEC,  3'b000);
        pkt_valid = 1'b0;                 step(S_DEC,  3'b000);
        sft_rst = 3'b000;

        // Soft reset while waiting
        fifo_empty = 3'b011; hdr(8'h02);  step(S_WAIT, 3'b100);
        pkt_valid = 1'b0; sft_rst = 3'b100; step(S_DEC, 3'b000);
        sft_rst = 3'b000; fifo_empty = 3'b111;

        // Synchronous reset mid-packet
        hdr(8'h01);                       step(S_LFD,  3'b010);
        rst = 1'b1; pkt_valid = 1'b0;     step(S_DEC,  3'b000);
        rst = 1'b0;                       step(S_DEC,  3'b000);

`ifdef ROUTER_FSM_TIMEOUT_EN
        // Port 0 never drains: WL cycles in WAIT, then drop with one pulse
        fifo_empty = 3'b110; hdr(8'h00);  step(S_WAIT, 3'b001);
        for (int i = 0; i < WL - 1; i++)  step(S_WAIT, 3'b001);
        step(S_DROP, 3'b000, 1'b1);
        pkt_valid = 1'b0;                 step(S_DEC,  3'b000, 1'b0);
        fifo_empty = 3'b111;
`endif

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
